// File: rtl/camera_orbit_ctrl.sv
`timescale 1ns/1ps
// camera_orbit_ctrl
//   Orbit-camera state holder feeding the camera basis stage. Keeps phi, theta
//   and zoom magnitude, updates them from single-cycle button pulses and, at a
//   frame boundary with pending changes, produces Q2.14 sin/cos of phi/theta
//   from a registered quarter-wave ROM. Results appear together with mag_int
//   and a one-cycle valid pulse.
//   Optional feature: define AUTO_ORBIT_EN for automatic theta stepping every
//   AUTO_DIV cycles.
// Ports
//   clk_in, rst_in (sync, active high)
//   phi_inc_in/phi_dec_in, theta_inc_in/theta_dec_in, zoom_in_in/zoom_out_in
//   frame_start_in  start-of-frame pulse
//   cos/sin_phi_out, cos/sin_theta_out  Q2.14 results
//   mag_int_out     zoom magnitude 1..7
//   valid_out       one-cycle pulse, all outputs new
//   busy_out        FSM not idle
module camera_orbit_ctrl #(
  parameter logic [7:0] PHI_MIN    = 8'd8,
  parameter logic [7:0] PHI_MAX    = 8'd120,
  parameter logic [7:0] PHI_INIT   = 8'd64,
  parameter logic [7:0] THETA_INIT = 8'd0,
  parameter logic [2:0] MAG_INIT   = 3'd4,
  parameter int         AUTO_DIV   = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        phi_inc_in,
  input  logic        phi_dec_in,
  input  logic        theta_inc_in,
  input  logic        theta_dec_in,
  input  logic        zoom_in_in,
  input  logic        zoom_out_in,
  input  logic        frame_start_in,
  output logic [15:0] cos_phi_out,
  output logic [15:0] sin_phi_out,
  output logic [15:0] cos_theta_out,
  output logic [15:0] sin_theta_out,
  output logic [2:0]  mag_int_out,
  output logic        valid_out,
  output logic        busy_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_SNAP, S_RD0, S_RD1, S_RD2, S_RD3, S_DRAIN, S_EMIT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phi_q, phi_d, theta_q, theta_d;
  logic [2:0]  mag_q, mag_d;
  logic        dirty_q, dirty_d;
  logic [7:0]  sh_phi_q, sh_theta_q;
  logic [2:0]  sh_mag_q;
  logic [14:0] rom_q;
  logic        neg_q;
  logic [15:0] hold_sp_q, hold_cp_q, hold_st_q, hold_ct_q;
  logic [7:0]  rd_ang;
  logic [6:0]  rom_idx;
  logic [15:0] rom_ext, rom_val;

  // Quarter-wave table L[k] = round(16384*sin(k*pi/128)), k = 0..64
  function automatic logic [14:0] sin_lut(input logic [6:0] k);
    case (k)
      7'd0:  sin_lut = 15'd0;     7'd1:  sin_lut = 15'd402;   7'd2:  sin_lut = 15'd804;   7'd3:  sin_lut = 15'd1205;
      7'd4:  sin_lut = 15'd1606;  7'd5:  sin_lut = 15'd2006;  7'd6:  sin_lut = 15'd2404;  7'd7:  sin_lut = 15'd2801;
      7'd8:  sin_lut = 15'd3196;  7'd9:  sin_lut = 15'd3590;  7'd10: sin_lut = 15'd3981;  7'd11: sin_lut = 15'd4370;
      7'd12: sin_lut = 15'd4756;  7'd13: sin_lut = 15'd5139;  7'd14: sin_lut = 15'd5520;  7'd15: sin_lut = 15'd5897;
      7'd16: sin_lut = 15'd6270;  7'd17: sin_lut = 15'd6639;  7'd18: sin_lut = 15'd7005;  7'd19: sin_lut = 15'd7366;
      7'd20: sin_lut = 15'd7723;  7'd21: sin_lut = 15'd8076;  7'd22: sin_lut = 15'd8423;  7'd23: sin_lut = 15'd8765;
      7'd24: sin_lut = 15'd9102;  7'd25: sin_lut = 15'd9434;  7'd26: sin_lut = 15'd9760;  7'd27: sin_lut = 15'd10080;
      7'd28: sin_lut = 15'd10394; 7'd29: sin_lut = 15'd10702; 7'd30: sin_lut = 15'd11003; 7'd31: sin_lut = 15'd11297;
      7'd32: sin_lut = 15'd11585; 7'd33: sin_lut = 15'd11866; 7'd34: sin_lut = 15'd12140; 7'd35: sin_lut = 15'd12406;
      7'd36: sin_lut = 15'd12665; 7'd37: sin_lut = 15'd12916; 7'd38: sin_lut = 15'd13160; 7'd39: sin_lut = 15'd13395;
      7'd40: sin_lut = 15'd13623; 7'd41: sin_lut = 15'd13842; 7'd42: sin_lut = 15'd14053; 7'd43: sin_lut = 15'd14256;
      7'd44: sin_lut = 15'd14449; 7'd45: sin_lut = 15'd14635; 7'd46: sin_lut = 15'd14811; 7'd47: sin_lut = 15'd14978;
      7'd48: sin_lut = 15'd15137; 7'd49: sin_lut = 15'd15286; 7'd50: sin_lut = 15'd15426; 7'd51: sin_lut = 15'd15557;
      7'd52: sin_lut = 15'd15679; 7'd53: sin_lut = 15'd15791; 7'd54: sin_lut = 15'd15893; 7'd55: sin_lut = 15'd15986;
      7'd56: sin_lut = 15'd16069; 7'd57: sin_lut = 15'd16143; 7'd58: sin_lut = 15'd16207; 7'd59: sin_lut = 15'd16261;
      7'd60: sin_lut = 15'd16305; 7'd61: sin_lut = 15'd16340; 7'd62: sin_lut = 15'd16364; 7'd63: sin_lut = 15'd16379;
      7'd64: sin_lut = 15'd16384;
      default: sin_lut = 15'd0;
    endcase
  endfunction

`ifdef AUTO_ORBIT_EN
  logic [31:0] auto_cnt_q;
  logic        auto_wrap;
  assign auto_wrap = (auto_cnt_q == 32'(AUTO_DIV - 1));
  always_ff @(posedge clk_in) begin
    if (rst_in || auto_wrap) auto_cnt_q <= '0;
    else                     auto_cnt_q <= auto_cnt_q + 32'd1;
  end
`endif

  // Camera state next-value logic; opposing pulses on one axis cancel.
  always_comb begin
    phi_d = phi_q;
    if (phi_inc_in && !phi_dec_in && phi_q < PHI_MAX)      phi_d = phi_q + 8'd1;
    else if (phi_dec_in && !phi_inc_in && phi_q > PHI_MIN) phi_d = phi_q - 8'd1;

    theta_d = theta_q;
    if (theta_inc_in && !theta_dec_in)      theta_d = theta_q + 8'd1;
    else if (theta_dec_in && !theta_inc_in) theta_d = theta_q - 8'd1;
`ifdef AUTO_ORBIT_EN
    // Any manual theta activity in the wrap cycle swallows the auto step.
    if (auto_wrap && !theta_inc_in && !theta_dec_in) theta_d = theta_q + 8'd1;
`endif

    mag_d = mag_q;
    if (zoom_out_in && !zoom_in_in && mag_q < 3'd7)      mag_d = mag_q + 3'd1;
    else if (zoom_in_in && !zoom_out_in && mag_q > 3'd1) mag_d = mag_q - 3'd1;

    // A change landing in the SNAP cycle is not in the snapshot, so it must stay pending.
    dirty_d = (state_q == S_SNAP) ? 1'b0 : dirty_q;
    if (phi_d != phi_q || theta_d != theta_q || mag_d != mag_q) dirty_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_start_in && dirty_q) state_d = S_SNAP;
      S_SNAP:  state_d = S_RD0;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_RD3;
      S_RD3:   state_d = S_DRAIN;
      S_DRAIN: state_d = S_EMIT;
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ROM address: cos is sin shifted by a quarter turn.
  always_comb begin
    case (state_q)
      S_RD0:   rd_ang = sh_phi_q;
      S_RD1:   rd_ang = sh_phi_q + 8'd64;
      S_RD2:   rd_ang = sh_theta_q;
      S_RD3:   rd_ang = sh_theta_q + 8'd64;
      default: rd_ang = 8'd0;
    endcase
    rom_idx = rd_ang[6] ? (7'd64 - {1'b0, rd_ang[5:0]}) : {1'b0, rd_ang[5:0]};
  end

  assign rom_ext  = {1'b0, rom_q};
  assign rom_val  = neg_q ? (16'd0 - rom_ext) : rom_ext;
  assign busy_out = (state_q != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      phi_q         <= PHI_INIT;
      theta_q       <= THETA_INIT;
      mag_q         <= MAG_INIT;
      dirty_q       <= 1'b1;
      sh_phi_q      <= '0;
      sh_theta_q    <= '0;
      sh_mag_q      <= '0;
      rom_q         <= '0;
      neg_q         <= 1'b0;
      hold_sp_q     <= '0;
      hold_cp_q     <= '0;
      hold_st_q     <= '0;
      hold_ct_q     <= '0;
      sin_phi_out   <= '0;
      cos_phi_out   <= '0;
      sin_theta_out <= '0;
      cos_theta_out <= '0;
      mag_int_out   <= '0;
      valid_out     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi_q     <= phi_d;
      theta_q   <= theta_d;
      mag_q     <= mag_d;
      dirty_q   <= dirty_d;
      rom_q     <= sin_lut(rom_idx);
      neg_q     <= rd_ang[7];
      valid_out <= 1'b0;
      if (state_q == S_SNAP) begin
        sh_phi_q   <= phi_q;
        sh_theta_q <= theta_q;
        sh_mag_q   <= mag_q;
      end
      // Each ROM result arrives one state after its address was issued.
      if (state_q == S_RD1)   hold_sp_q <= rom_val;
      if (state_q == S_RD2)   hold_cp_q <= rom_val;
      if (state_q == S_RD3)   hold_st_q <= rom_val;
      if (state_q == S_DRAIN) hold_ct_q <= rom_val;
      if (state_q == S_EMIT) begin
        sin_phi_out   <= hold_sp_q;
        cos_phi_out   <= hold_cp_q;
        sin_theta_out <= hold_st_q;
        cos_theta_out <= hold_ct_q;
        mag_int_out   <= sh_mag_q;
        valid_out     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_camera_orbit_ctrl.sv
`timescale 1ns/1ps
// Directed bench for camera_orbit_ctrl with hand-computed Q2.14 expectations.
module tb_camera_orbit_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        phi_inc_in = 1'b0, phi_dec_in = 1'b0, theta_inc_in = 1'b0, theta_dec_in = 1'b0;
  logic        zoom_in_in = 1'b0, zoom_out_in = 1'b0, frame_start_in = 1'b0;
  logic [15:0] cos_phi_out, sin_phi_out, cos_theta_out, sin_theta_out;
  logic [2:0]  mag_int_out;
  logic        valid_out, busy_out;

  int n_chk = 0;
  int n_err = 0;
  bit busy_seen;

  camera_orbit_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .phi_inc_in(phi_inc_in), .phi_dec_in(phi_dec_in),
    .theta_inc_in(theta_inc_in), .theta_dec_in(theta_dec_in),
    .zoom_in_in(zoom_in_in), .zoom_out_in(zoom_out_in),
    .frame_start_in(frame_start_in),
    .cos_phi_out(cos_phi_out), .sin_phi_out(sin_phi_out),
    .cos_theta_out(cos_theta_out), .sin_theta_out(sin_theta_out),
    .mag_int_out(mag_int_out), .valid_out(valid_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mask: [0]phi_inc [1]phi_dec [2]theta_inc [3]theta_dec [4]zoom_in [5]zoom_out
  task automatic set_btn(input logic [5:0] m);
    {zoom_out_in, zoom_in_in, theta_dec_in, theta_inc_in, phi_dec_in, phi_inc_in} = m;
  endtask

  task automatic pulse(input logic [5:0] m, input int cnt);
    repeat (cnt) begin
      set_btn(m);
      @(posedge clk_in); #1;
    end
    set_btn(6'd0);
  endtask

  task automatic chk_out(input string tag, input int sp, input int cp, input int st, input int ct, input int mg);
    chk({tag, ".sin_phi"},   $signed(sin_phi_out),   sp);
    chk({tag, ".cos_phi"},   $signed(cos_phi_out),   cp);
    chk({tag, ".sin_theta"}, $signed(sin_theta_out), st);
    chk({tag, ".cos_theta"}, $signed(cos_theta_out), ct);
    chk({tag, ".mag"},       int'(mag_int_out),      mg);
  endtask

  // Frame trigger sampled at edge k; edge k+n is observed in iteration n.
  // inj_n: buttons in inj_m are sampled at edge k+inj_n; rst_at: rst sampled at edge k+rst_at.
  task automatic frame(input string tag, input bit exp_v, input int inj_n, input logic [5:0] inj_m, input int rst_at);
    int lat, nv;
    lat = 0; nv = 0; busy_seen = 0;
    frame_start_in = 1'b1;
    @(posedge clk_in); #1;
    frame_start_in = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      set_btn(n == inj_n ? inj_m : 6'd0);
      rst_in = (n == rst_at);
      @(posedge clk_in); #1;
      busy_seen |= busy_out;
      if (valid_out) begin
        nv++;
        if (lat == 0) lat = n;
      end
    end
    set_btn(6'd0);
    rst_in = 1'b0;
    if (exp_v) begin
      chk({tag, ".latency"}, lat, 7);
      chk({tag, ".nvalid"}, nv, 1);
    end else begin
      chk({tag, ".novalid"}, nv, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.valid", int'(valid_out), 0);
    chk("reset.busy",  int'(busy_out), 0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // 1: initial state phi=64, theta=0, mag=4
    frame("t1", 1'b1, 0, 6'd0, 0);
    chk_out("t1", 16384, 0, 0, 16384, 4);
    chk("t1.busy_after", int'(busy_out), 0);

    // 2: theta=64, then theta wraps to 255
    pulse(6'b000100, 64);
    frame("t2a", 1'b1, 0, 6'd0, 0);
    chk_out("t2a", 16384, 0, 16384, 0, 4);
    pulse(6'b001000, 65);
    frame("t2b", 1'b1, 0, 6'd0, 0);
    chk_out("t2b", 16384, 0, -402, 16379, 4);

    // 3: phi saturates at 8, mag at 7
    pulse(6'b000010, 200);
    pulse(6'b100000, 10);
    frame("t3", 1'b1, 0, 6'd0, 0);
    chk_out("t3", 3196, 16069, -402, 16379, 7);
    pulse(6'b110000, 1);
    pulse(6'b000011, 1);
    // 4: nothing changed -> no computation
    frame("t4", 1'b0, 0, 6'd0, 0);
    chk("t4.busy", int'(busy_seen), 0);
    chk("t4.mag", int'(mag_int_out), 7);

    // 5: phi -> 9; phi_inc sampled during RD1 must not leak into this result
    pulse(6'b000001, 1);
    frame("t5a", 1'b1, 3, 6'b000001, 0);
    chk("t5a.busy", int'(busy_seen), 1);
    chk_out("t5a", 3590, 15986, -402, 16379, 7);
    frame("t5b", 1'b1, 0, 6'd0, 0);
    chk_out("t5b", 3981, 15893, -402, 16379, 7);

    // 6: reset during RD2 aborts; outputs cleared; next frame uses reset state
    pulse(6'b000001, 1);
    frame("t6a", 1'b0, 0, 6'd0, 4);
    chk_out("t6a", 0, 0, 0, 0, 0);
    frame("t6b", 1'b1, 0, 6'd0, 0);
    chk_out("t6b", 16384, 0, 0, 16384, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
